// File: rtl/instruction_fetch_unit.sv
// RV64 fetch front end: PC, single-outstanding imem fetch, redirect and misaligned-target halt.
// Latency: memory latency + 1 from request accept to instr_valid; holds word while !instr_ready.
module instruction_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_offset,
  input  logic            redirect_clear_lsb,
  output logic            fetch_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend;
  logic            r_discard;
  logic [31:0]     r_instruction;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_fetch_error;

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_newest;
  logic            w_misaligned;

  assign w_sum        = redirect_base + redirect_offset;
  assign w_target     = {w_sum[XLEN-1:1], w_sum[0] & ~redirect_clear_lsb};
  assign w_misaligned = redirect_valid && (w_target[1:0] != 2'b00);
  // A same-cycle redirect is always newer than anything already pending.
  assign w_newest     = redirect_valid ? w_target : r_pend_pc;

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == S_HOLD);
  assign instruction    = r_instruction;
  assign instr_pc       = r_instr_pc;
  assign fetch_error    = r_fetch_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pend_pc     <= RESET_PC;
      r_pend        <= 1'b0;
      r_discard     <= 1'b0;
      r_instruction <= 32'h0;
      r_instr_pc    <= '0;
      r_fetch_error <= 1'b0;
    end else if (r_state != S_HALT && w_misaligned) begin
      r_state       <= S_HALT;
      r_fetch_error <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) r_pc <= w_target;
          r_state <= S_REQ;
        end
        S_REQ: begin
          // The request address stays put; the redirect is replayed after the response.
          if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= w_target;
          end
          if (imem_req_ready) begin
            r_state   <= S_WAIT;
            r_discard <= r_pend || redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (r_discard || redirect_valid) begin
              r_pc      <= w_newest;
              r_pend    <= 1'b0;
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_instruction <= imem_resp_data;
              r_instr_pc    <= r_pc;
              r_pc          <= r_pc + XLEN'(4);
              r_state       <= S_HOLD;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= w_target;
            r_discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (instr_ready) begin
            r_state <= S_REQ;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (next expected PC, advanced by deliveries and replaced by redirects).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_base = 64'h0;
  logic [63:0] redirect_offset = 64'h0;
  logic        redirect_clear_lsb = 1'b0;
  logic        fetch_error;

  int errors = 0;
  int checks = 0;

  // memory model state
  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat = 1;
  logic [63:0] mem_addr;
  bit          rdy_force = 1'b1;
  bit          rdy_block = 1'b0;
  bit          prev_stall;
  logic [63:0] prev_addr;

  // reference model and per-step events
  logic [63:0] exp_pc;
  bit          halted;
  bit          ev_hs, ev_rise, ev_overlap, ev_addr_moved;
  logic [63:0] ev_hs_addr, ev_exp_pc;

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base),
    .redirect_offset(redirect_offset), .redirect_clear_lsb(redirect_clear_lsb),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00700013;
      64'h4:   return 32'h00003C03;
      64'h8:   return 32'h015C0463;
      default: return (a[31:0] * 32'h9E3779B9) ^ a[63:32] ^ 32'h13572468;
    endcase
  endfunction

  task automatic set_redirect(input logic [63:0] b, input logic [63:0] o, input logic clr);
    redirect_valid     = 1'b1;
    redirect_base      = b;
    redirect_offset    = o;
    redirect_clear_lsb = clr;
  endtask

  // One clock cycle: memory drives its outputs, the edge happens, models update at edge+1.
  task automatic step();
    bit          hs_now, rd, was_valid, stall_now;
    logic [63:0] hs_a, tgt;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? word_at(mem_addr) : 32'hDEADBEEF;
    imem_req_ready  = rdy_force ? 1'b1 : (rdy_block ? 1'b0 : ($urandom_range(0, 99) < 70));
    ev_overlap    = imem_req_valid && mem_busy;
    ev_addr_moved = prev_stall && imem_req_valid && (imem_req_addr != prev_addr);
    hs_now    = imem_req_valid && imem_req_ready;
    stall_now = imem_req_valid && !imem_req_ready;
    hs_a      = imem_req_addr;
    was_valid = instr_valid;
    rd        = redirect_valid;
    tgt       = redirect_base + redirect_offset;
    if (redirect_clear_lsb) tgt[0] = 1'b0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (imem_resp_valid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs_now) begin
      mem_busy = 1'b1;
      mem_addr = hs_a;
      mem_cnt  = mem_lat - 1;
    end
    prev_stall = stall_now;
    prev_addr  = hs_a;
    ev_hs      = hs_now;
    ev_hs_addr = hs_a;
    if (rd && !halted) begin
      if (tgt[1:0] != 2'b00) halted = 1'b1;
      else exp_pc = tgt;
    end
    ev_rise = instr_valid && !was_valid;
    if (ev_rise) begin
      ev_exp_pc = exp_pc;
      exp_pc    = exp_pc + 64'd4;
    end
  endtask

  task automatic assert_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    exp_pc         = 64'h0;
    halted         = 1'b0;
    prev_stall     = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_instr(output bit ok);
    int n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    ok = instr_valid;
  endtask

  task automatic test_reset();
    assert_reset();
    checks += 6;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h expected 0", instruction); end
    if (instr_pc !== 64'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_fetch_error: got %b expected 0", fetch_error); end
    release_reset();
  endtask

  task automatic test_basic();
    rdy_force = 1'b1;
    mem_lat   = 1;
    step();
    checks += 2;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %b expected 1", imem_req_valid); end
    if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL basic_req_addr: got %h expected 0", imem_req_addr); end
    step();
    checks += 2;
    if (!(ev_hs && ev_hs_addr === 64'h0)) begin errors++; $display("FAIL basic_handshake: got hs=%b addr=%h expected hs=1 addr=0", ev_hs, ev_hs_addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", instr_valid); end
    step();
    checks += 3;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got instr_valid=%b expected 1", instr_valid); end
    if (instruction !== 32'h00700013) begin errors++; $display("FAIL basic_instruction: got %h expected 00700013", instruction); end
    if (instr_pc !== 64'h0) begin errors++; $display("FAIL basic_instr_pc: got %h expected 0", instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks += 2;
    if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_next_req: got req=%b ivalid=%b expected 1/0", imem_req_valid, instr_valid); end
    if (imem_req_addr !== 64'h4) begin errors++; $display("FAIL basic_next_addr: got %h expected 4", imem_req_addr); end
  endtask

  task automatic test_backpressure();
    step();
    step();
    checks += 2;
    if (instruction !== 32'h00003C03) begin errors++; $display("FAIL bp_instruction: got %h expected 00003c03", instruction); end
    if (instr_pc !== 64'h4) begin errors++; $display("FAIL bp_instr_pc: got %h expected 4", instr_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 1;
      if (instr_valid !== 1'b1 || instruction !== 32'h00003C03 || instr_pc !== 64'h4 || imem_req_valid !== 1'b0)
        begin errors++; $display("FAIL bp_hold_%0d: got v=%b ins=%h pc=%h req=%b expected 1/00003c03/4/0", i, instr_valid, instruction, instr_pc, imem_req_valid); end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8) begin errors++; $display("FAIL bp_next_addr: got req=%b addr=%h expected 1/8", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    bit seen = 1'b0;
    mem_lat = 3;
    step();
    checks += 1;
    if (!(ev_hs && ev_hs_addr === 64'h8)) begin errors++; $display("FAIL rw_handshake: got hs=%b addr=%h expected 1/8", ev_hs, ev_hs_addr); end
    set_redirect(64'h40, 64'hFFFF_FFFF_FFFF_FFE0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (instr_valid) seen = 1'b1;
    end
    checks += 2;
    if (seen) begin errors++; $display("FAIL rw_discard: got instr_valid=1 expected 0"); end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h20) begin errors++; $display("FAIL rw_target: got req=%b addr=%h expected 1/20", imem_req_valid, imem_req_addr); end
    mem_lat = 1;
  endtask

  task automatic test_redirect_req();
    bit ok;
    rdy_force = 1'b0;
    rdy_block = 1'b1;
    set_redirect(64'h100, 64'h0, 1'b0);
    step();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h20) begin errors++; $display("FAIL rr_stable1: got req=%b addr=%h expected 1/20", imem_req_valid, imem_req_addr); end
    set_redirect(64'h200, 64'h10, 1'b0);
    step();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h20) begin errors++; $display("FAIL rr_stable2: got req=%b addr=%h expected 1/20", imem_req_valid, imem_req_addr); end
    rdy_block = 1'b0;
    rdy_force = 1'b1;
    step();
    checks += 1;
    if (!(ev_hs && ev_hs_addr === 64'h20)) begin errors++; $display("FAIL rr_handshake: got hs=%b addr=%h expected 1/20", ev_hs, ev_hs_addr); end
    step();
    checks += 1;
    if (instr_valid !== 1'b0 || imem_req_addr !== 64'h210) begin errors++; $display("FAIL rr_latest_target: got v=%b addr=%h expected 0/210", instr_valid, imem_req_addr); end
    wait_instr(ok);
    checks += 1;
    if (!ok || instr_pc !== 64'h210 || instruction !== word_at(64'h210))
      begin errors++; $display("FAIL rr_fetch: got v=%b pc=%h ins=%h expected 1/210/%h", ok, instr_pc, instruction, word_at(64'h210)); end
  endtask

  task automatic test_jalr_misaligned();
    bit ok;
    set_redirect(64'h1005, 64'h0, 1'b1);
    step();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1004) begin errors++; $display("FAIL jalr_addr: got req=%b addr=%h expected 1/1004", imem_req_valid, imem_req_addr); end
    wait_instr(ok);
    checks += 2;
    if (!ok || instr_pc !== 64'h1004 || instruction !== word_at(64'h1004))
      begin errors++; $display("FAIL jalr_fetch: got v=%b pc=%h ins=%h expected 1/1004/%h", ok, instr_pc, instruction, word_at(64'h1004)); end
    if (fetch_error !== 1'b0) begin errors++; $display("FAIL jalr_no_error: got %b expected 0", fetch_error); end
    set_redirect(64'h8, 64'h6, 1'b0);
    step();
    checks += 1;
    if (fetch_error !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL misaligned_halt: got err=%b req=%b v=%b expected 1/0/0", fetch_error, imem_req_valid, instr_valid); end
    rdy_force = 1'b0;
    for (int i = 0; i < 12; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) set_redirect({32'h0, $urandom} & ~64'h3, 64'h0, 1'b0);
      step();
      checks += 1;
      if (fetch_error !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
        begin errors++; $display("FAIL halt_sticky_%0d: got err=%b req=%b v=%b expected 1/0/0", i, fetch_error, imem_req_valid, instr_valid); end
    end
    rdy_force   = 1'b1;
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    assert_reset();
    release_reset();
    set_redirect(64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 1'b0);
    step();
    checks += 1;
    if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_idle_redirect: got %h expected fffffffffffffffc", imem_req_addr); end
    wait_instr(ok);
    checks += 1;
    if (!ok || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got v=%b pc=%h expected 1/fffffffffffffffc", ok, instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    assert_reset();
    release_reset();
    wait_instr(ok);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    mem_lat = 3;
    step();
    checks += 1;
    if (!(ev_hs && ev_hs_addr === 64'h4)) begin errors++; $display("FAIL rst_setup: got hs=%b addr=%h expected 1/4", ev_hs, ev_hs_addr); end
    assert_reset();
    checks += 1;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h0 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 64'h0 || fetch_error !== 1'b0)
      begin errors++; $display("FAIL rst_in_wait: got req=%b addr=%h v=%b ins=%h pc=%h err=%b expected all 0", imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc, fetch_error); end
    release_reset();
    mem_lat = 1;
    step();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_wait_restart: got req=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr); end
    set_redirect(64'h2, 64'h0, 1'b0);
    step();
    checks += 1;
    if (fetch_error !== 1'b1) begin errors++; $display("FAIL rst_halt_entry: got %b expected 1", fetch_error); end
    assert_reset();
    checks += 1;
    if (fetch_error !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_in_halt: got err=%b req=%b expected 0/0", fetch_error, imem_req_valid); end
    release_reset();
    step();
    checks += 1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_halt_restart: got req=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_random();
    bit          hp;
    logic [63:0] hpc, t, o;
    logic [31:0] hin;
    bit          clr;
    int          deliveries = 0;
    assert_reset();
    release_reset();
    rdy_force = 1'b0;
    rdy_block = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 99) < 60);
      mem_lat     = $urandom_range(1, 3);
      if ($urandom_range(0, 99) < 8) begin
        t      = {$urandom, $urandom};
        t[1:0] = 2'b00;
        o      = {$urandom, $urandom};
        clr    = 1'($urandom_range(0, 1));
        set_redirect(clr ? (t - o + 64'd1) : (t - o), o, clr);
      end
      hp  = instr_valid && !instr_ready && !redirect_valid;
      hpc = instr_pc;
      hin = instruction;
      step();
      checks += 3;
      if (ev_overlap) begin errors++; $display("FAIL rnd_overlap: got request while busy at cycle %0d expected none", i); end
      if (ev_addr_moved) begin errors++; $display("FAIL rnd_addr_stable: got %h expected %h at cycle %0d", imem_req_addr, prev_addr, i); end
      if (fetch_error !== 1'b0) begin errors++; $display("FAIL rnd_error: got %b expected 0 at cycle %0d", fetch_error, i); end
      if (hp) begin
        checks += 1;
        if (instr_valid !== 1'b1 || instr_pc !== hpc || instruction !== hin)
          begin errors++; $display("FAIL rnd_hold: got v=%b pc=%h ins=%h expected 1/%h/%h", instr_valid, instr_pc, instruction, hpc, hin); end
      end
      if (ev_rise) begin
        deliveries++;
        checks += 2;
        if (instr_pc !== ev_exp_pc) begin errors++; $display("FAIL rnd_pc: got %h expected %h at cycle %0d", instr_pc, ev_exp_pc, i); end
        if (instruction !== word_at(ev_exp_pc)) begin errors++; $display("FAIL rnd_word: got %h expected %h at cycle %0d", instruction, word_at(ev_exp_pc), i); end
      end
    end
    checks += 1;
    if (deliveries < 50) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 50", deliveries); end
    rdy_force = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_jalr_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
